// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with run-time CPOL/CPHA/bit order and NUM_CS one-hot-low chip selects.
module spi_master_multi #(
  parameter int DATA_W = 8,
  parameter int HALF_DIV = 2,
  parameter int NUM_CS = 4,
  localparam int CS_W = $clog2(NUM_CS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] data_in,
  input  logic              miso,
  output logic              sck,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              new_data
);
  typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;
  localparam int TOG_W = $clog2(2*DATA_W+1);
  localparam logic [7:0] DIV_MAX = 8'(HALF_DIV-1);
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(2*DATA_W);
  state_t r_state, w_next;
  logic [7:0] r_div;
  logic [TOG_W-1:0] r_tog;
  logic r_cpol, r_cpha, r_lsb, r_sck, r_mosi, r_new_data;
  logic [CS_W-1:0] r_cs_sel;
  logic [DATA_W-1:0] r_tx, r_rx, r_data_out;
  logic w_div_end, w_edge, w_last, w_sample, w_shift, w_tx_bit, w_first, w_done;
  logic [TOG_W-1:0] w_tog_n;
  logic [DATA_W-1:0] w_tx_nxt, w_rx_nxt, w_in_shifted;
  assign w_div_end = r_div == DIV_MAX;
  assign w_tog_n = r_tog + TOG_W'(1);
  assign w_edge = r_state == TRANSFER && w_div_end;
  assign w_last = w_tog_n == TOG_LAST;
  // odd toggles are leading edges; cpha picks which parity samples and which shifts
  assign w_sample = w_edge && (w_tog_n[0] ^ r_cpha);
  assign w_shift = w_edge && (r_cpha ? w_tog_n[0] : (!w_tog_n[0] && !w_last));
  assign w_tx_bit = r_lsb ? r_tx[0] : r_tx[DATA_W-1];
  assign w_tx_nxt = r_lsb ? r_tx >> 1 : r_tx << 1;
  assign w_rx_nxt = r_lsb ? {miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], miso};
  assign w_first = lsb_first ? data_in[0] : data_in[DATA_W-1];
  assign w_in_shifted = lsb_first ? data_in >> 1 : data_in << 1;
  assign w_done = r_state == HOLD && w_div_end && !abort;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     w_next = start ? SETUP : IDLE;
      SETUP:    w_next = w_div_end ? TRANSFER : SETUP;
      TRANSFER: w_next = (w_edge && w_last) ? HOLD : TRANSFER;
      HOLD:     w_next = w_div_end ? IDLE : HOLD;
    endcase
    if (abort && r_state != IDLE) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
      r_tog <= '0;
      r_cpol <= 1'b0;
      r_cpha <= 1'b0;
      r_lsb <= 1'b0;
      r_cs_sel <= '0;
      r_tx <= '0;
      r_rx <= '0;
      r_sck <= 1'b0;
      r_mosi <= 1'b0;
      r_new_data <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_new_data <= w_done;
      if (w_done) r_data_out <= r_rx;
      r_div <= (r_state == IDLE || w_next == IDLE || w_div_end) ? '0 : r_div + 8'd1;
      r_tog <= (w_next == IDLE) ? '0 : (w_edge ? w_tog_n : r_tog);
      if (r_state == IDLE) begin
        r_sck <= cpol;
        if (start) begin
          r_cpol <= cpol;
          r_cpha <= cpha;
          r_lsb <= lsb_first;
          r_cs_sel <= cs_sel;
          r_rx <= '0;
          r_tx <= cpha ? data_in : w_in_shifted;
          if (!cpha) r_mosi <= w_first;
        end
      end else if (abort) begin
        r_sck <= r_cpol;
      end else begin
        if (w_edge) r_sck <= ~r_sck;
        if (w_shift) begin
          r_mosi <= w_tx_bit;
          r_tx <= w_tx_nxt;
        end
        if (w_sample) r_rx <= w_rx_nxt;
      end
    end
  end
  always_comb begin
    cs_n = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (busy && r_cs_sel == CS_W'(i)) cs_n[i] = 1'b0;
  end
  assign busy = r_state != IDLE;
  assign sck = r_sck;
  assign mosi = r_mosi;
  assign data_out = r_data_out;
  assign new_data = r_new_data;
endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: directed checks of spi_master_multi at HALF_DIV=2 (u_dut0) and HALF_DIV=1 (u_dut1).
module tb_spi_master_multi;
  logic clk = 0, rst = 0, start0 = 0, start1 = 0, abort = 0;
  logic cpol = 0, cpha = 0, lsb_first = 0, tie1 = 0, miso0;
  logic [1:0] cs_sel = 0;
  logic [7:0] data_in = 0, sword = 8'h3C, cap0 = 0;
  logic sck0, mosi0, busy0, nd0, sck1, mosi1, busy1, nd1, prev0 = 0, prev1 = 0;
  logic [3:0] cs_n0, cs_n1, exp_cs0 = 4'hF, exp_cs1 = 4'hF;
  logic [7:0] dout0, dout1;
  int checks = 0, failures = 0, idx = 7;
  int busy_cnt0 = 0, nd_cnt0 = 0, rises0 = 0, cs_bad0 = 0;
  int busy_cnt1 = 0, nd_cnt1 = 0, rises1 = 0, cs_bad1 = 0;
  int b, n, r, c;
  always #5 clk = ~clk;
  assign miso0 = tie1 | sword[idx[2:0]];
  spi_master_multi #(.DATA_W(8), .HALF_DIV(2), .NUM_CS(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .cs_sel(cs_sel), .data_in(data_in), .miso(miso0),
    .sck(sck0), .mosi(mosi0), .cs_n(cs_n0), .data_out(dout0), .busy(busy0), .new_data(nd0));
  spi_master_multi #(.DATA_W(8), .HALF_DIV(1), .NUM_CS(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .cs_sel(cs_sel), .data_in(data_in), .miso(1'b1),
    .sck(sck1), .mosi(mosi1), .cs_n(cs_n1), .data_out(dout1), .busy(busy1), .new_data(nd1));
  // slave model: presents bits MSB first, advancing on each falling sck while selected
  always @(negedge clk) begin
    if (busy0) busy_cnt0++;
    if (nd0) nd_cnt0++;
    if (cs_n0 != (busy0 ? exp_cs0 : 4'hF)) cs_bad0++;
    if (busy0 && sck0 && !prev0) begin
      rises0++;
      cap0 = {cap0[6:0], mosi0};
    end
    if (!busy0) idx = 7;
    else if (!sck0 && prev0 && idx > 0) idx--;
    prev0 = sck0;
    if (busy1) busy_cnt1++;
    if (nd1) nd_cnt1++;
    if (cs_n1 != (busy1 ? exp_cs1 : 4'hF)) cs_bad1++;
    if (busy1 && sck1 && !prev1) rises1++;
    prev1 = sck1;
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic snap();
    b = busy_cnt0; n = nd_cnt0; r = rises0; c = cs_bad0;
  endtask
  task automatic go0();
    start0 = 1;
    tick();
    chk("busy_after_start", busy0, 1);
    start0 = 0;
  endtask
  task automatic wait_nd(input bit which);
    for (int t = 0; t < 120 && !(which ? nd1 : nd0); t++) tick();
    chk("new_data_seen", which ? nd1 : nd0, 1);
  endtask
  task automatic wait_rises(input int k);
    for (int t = 0; t < 120 && rises0 - r < k; t++) tick();
    chk("reach_toggle", rises0 - r, k);
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_sck", sck0, 0);
    chk("rst_mosi", mosi0, 0);
    chk("rst_cs", cs_n0, 4'hF);
    chk("rst_dout", dout0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_nd", nd0, 0);
    rst = 1;
    repeat (2) tick();
    exp_cs0 = 4'b1011; cs_sel = 2; data_in = 8'hA5; sword = 8'h3C;
    snap();
    go0();
    cpol = 1; cpha = 1; lsb_first = 1; cs_sel = 0; data_in = 8'h00;
    repeat (10) tick();
    cpol = 0; cpha = 0; lsb_first = 0; cs_sel = 2;
    wait_nd(0);
    tick();
    chk("m0_mosi", cap0, 8'hA5);
    chk("m0_busy", busy_cnt0 - b, 36);
    chk("m0_nd", nd_cnt0 - n, 1);
    chk("m0_rises", rises0 - r, 8);
    chk("m0_cs", cs_bad0 - c, 0);
    chk("m0_dout", dout0, 8'h3C);
    cpol = 1; cpha = 1; lsb_first = 1; cs_sel = 0; data_in = 8'h01; tie1 = 1; exp_cs0 = 4'b1110;
    repeat (2) tick();
    chk("m3_idle_sck", sck0, 1);
    snap();
    go0();
    wait_nd(0);
    chk("m3_dout", dout0, 8'hFF);
    tick();
    chk("m3_mosi", cap0, 8'h80);
    chk("m3_busy", busy_cnt0 - b, 36);
    chk("m3_cs", cs_bad0 - c, 0);
    chk("m3_end_sck", sck0, 1);
    tie1 = 0; cpol = 0; cpha = 0; lsb_first = 0; cs_sel = 2; exp_cs0 = 4'b1011;
    repeat (2) tick();
    data_in = 8'h12; sword = 8'h81; start0 = 1;
    tick();
    chk("b2b_busy1", busy0, 1);
    wait_nd(0);
    chk("b2b_mosi1", cap0, 8'h12);
    chk("b2b_dout1", dout0, 8'h81);
    chk("b2b_gap_cs", cs_n0, 4'hF);
    chk("b2b_gap_busy", busy0, 0);
    data_in = 8'h34; sword = 8'h3C;
    tick();
    chk("b2b_busy2", busy0, 1);
    chk("b2b_cs2", cs_n0, 4'b1011);
    start0 = 0;
    wait_nd(0);
    tick();
    chk("b2b_mosi2", cap0, 8'h34);
    chk("b2b_dout2", dout0, 8'h3C);
    sword = 8'h99;
    snap();
    go0();
    wait_rises(3);
    abort = 1;
    tick();
    abort = 0;
    chk("ab_busy", busy0, 0);
    chk("ab_cs", cs_n0, 4'hF);
    chk("ab_sck", sck0, 0);
    repeat (40) tick();
    chk("ab_nd", nd_cnt0 - n, 0);
    chk("ab_dout", dout0, 8'h3C);
    chk("ab_cs_all", cs_bad0 - c, 0);
    sword = 8'hC3;
    snap();
    go0();
    wait_rises(5);
    rst = 0;
    #1;
    chk("rr_cs", cs_n0, 4'hF);
    chk("rr_sck", sck0, 0);
    chk("rr_busy", busy0, 0);
    chk("rr_dout", dout0, 0);
    tick();
    rst = 1;
    tick();
    chk("rr_nd", nd_cnt0 - n, 0);
    data_in = 8'h5A;
    snap();
    go0();
    wait_nd(0);
    chk("rr_dout2", dout0, 8'hC3);
    tick();
    chk("rr_mosi2", cap0, 8'h5A);
    chk("rr_busy2", busy_cnt0 - b, 36);
    cs_sel = 3; exp_cs1 = 4'b0111; data_in = 8'hA5;
    b = busy_cnt1; n = nd_cnt1; r = rises1; c = cs_bad1;
    start1 = 1;
    tick();
    start1 = 0;
    chk("hd1_busy", busy1, 1);
    chk("hd1_cs", cs_n1, 4'b0111);
    repeat (3) tick();
    cpol = 1;
    repeat (3) tick();
    cpol = 0;
    wait_nd(1);
    chk("hd1_dout", dout1, 8'hFF);
    tick();
    chk("hd1_busy_len", busy_cnt1 - b, 18);
    chk("hd1_rises", rises1 - r, 8);
    chk("hd1_cs_all", cs_bad1 - c, 0);
    chk("hd1_nd", nd_cnt1 - n, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
